sum3_method_responder: RTL

// - Callee (responder) end of the method-call handshake (<m>_req / <m>_busy / <m>_return).
// - Accepts three signed WIDTH-bit arguments and accumulates them serially, one add per cycle.
// - Returns the signed sum, a signed-overflow flag and an is-zero boolean.
// - Sits under a Synthesijer-generated caller, or under a sim_* bench that holds sum_req high and waits for sum_busy==0.

---
 rtl/method_if_pkg.sv | 17 +
 rtl/method_req_edge.sv | 19 +
 rtl/sum3_method_responder.sv | 93 +++++++++
 3 files changed

// File: rtl/method_if_pkg.sv
// method_if_pkg: shared definitions for method-call responder blocks
//   state_t         : responder FSM encoding (3 bits, S_IDLE..S_DONE)
//   MAX_START_DELAY : largest supported start delay, sizes the delay counter
//   add_ovf()       : signed-overflow test from the sign bits of one add
package method_if_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_ADD1  = 3'd2,
        S_ADD2  = 3'd3,
        S_DONE  = 3'd4
    } state_t;
    localparam int MAX_START_DELAY = 15;
    function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction
endpackage

// File: rtl/method_req_edge.sv
// method_req_edge: rising-edge detector for a level method request
//   clk, reset : clock, asynchronous active-high reset
//   req        : level request from the caller
//   idle       : callee is ready to accept a call
//   start      : one-cycle pulse, request rose while idle
module method_req_edge (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic idle,
    output logic start
);
    logic req_d;
    // Held low through reset so a request already high at release counts as a new edge.
    always_ff @(posedge clk or posedge reset)
        if (reset) req_d <= 1'b0;
        else req_d <= req;
    assign start = req & ~req_d & idle;
endmodule

// File: rtl/sum3_method_responder.sv
// sum3_method_responder: callee for sum(c1,c2,c3) with serial accumulation
//   clk, reset         : clock, asynchronous active-high reset
//   sum_c1..sum_c3     : signed arguments, latched at call start
//   sum_req            : level request, a rising edge starts one call
//   sum_busy           : high while a call is in progress
//   sum_return         : wrapped sum of the three arguments
//   sum_ovf, sum_zero  : signed overflow in either partial add, result is zero
module sum3_method_responder
    import method_if_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int START_DELAY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sum_c1,
    input  logic [WIDTH-1:0] sum_c2,
    input  logic [WIDTH-1:0] sum_c3,
    input  logic             sum_req,
    output logic             sum_busy,
    output logic [WIDTH-1:0] sum_return,
    output logic             sum_ovf,
    output logic             sum_zero
);
    localparam int CW = $clog2(MAX_START_DELAY + 1);
    localparam logic [CW-1:0] LAST = CW'(START_DELAY - 1);
    state_t state;
    logic [WIDTH-1:0] a1, a2, a3, acc, op_a, op_b, sum;
    logic [CW-1:0] cnt;
    logic ovf, start, idle;
    assign idle = (state == S_IDLE);
    method_req_edge u_edge (
        .clk  (clk),
        .reset(reset),
        .req  (sum_req),
        .idle (idle),
        .start(start)
    );
    // One adder shared by both partial sums.
    always_comb begin
        op_a = (state == S_ADD1) ? a1 : acc;
        op_b = (state == S_ADD1) ? a2 : a3;
        sum  = op_a + op_b;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= S_IDLE;
            a1         <= '0;
            a2         <= '0;
            a3         <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            cnt        <= '0;
            sum_busy   <= 1'b0;
            sum_return <= '0;
            sum_ovf    <= 1'b0;
            sum_zero   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a1       <= sum_c1;
                    a2       <= sum_c2;
                    a3       <= sum_c3;
                    acc      <= '0;
                    ovf      <= 1'b0;
                    cnt      <= '0;
                    sum_busy <= 1'b1;
                    // With no delay the latch state is skipped entirely.
                    state    <= (START_DELAY == 0) ? S_ADD1 : S_LATCH;
                end
                S_LATCH: if (cnt == LAST) state <= S_ADD1;
                         else cnt <= cnt + 1'b1;
                S_ADD1: begin
                    acc   <= sum;
                    ovf   <= ovf | add_ovf(op_a[WIDTH-1], op_b[WIDTH-1], sum[WIDTH-1]);
                    state <= S_ADD2;
                end
                S_ADD2: begin
                    acc   <= sum;
                    ovf   <= ovf | add_ovf(op_a[WIDTH-1], op_b[WIDTH-1], sum[WIDTH-1]);
                    state <= S_DONE;
                end
                S_DONE: begin
                    sum_return <= acc;
                    sum_zero   <= (acc == '0);
                    sum_ovf    <= ovf;
                    sum_busy   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule
